// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of N tri-state drive enables, with a forced all-off turnaround gap between owners.
// Optional macro HOLD_LIMIT_EN caps each ownership at MAX_HOLD consecutive cycles.
module tristate_bus_arbiter #(
   parameter int N        = 4,
   parameter int SW       = 2,
   parameter int TURN_CYC = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] sel,
   output logic          busy
);

   localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
   localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t         state_q;
   logic [N-1:0]   gnt_q;
   logic [SW-1:0]  sel_q;
   logic [SW-1:0]  ptr_q;
   logic           busy_q;
   logic [TW-1:0]  turnCnt_q;

   logic [SW-1:0]  winner_d;
   logic [SW-1:0]  ptr_d;
   logic [SW-1:0]  scanIdx;
   logic           found;
   logic           anyReq;
   logic           holdExpired;
   int             scanSum;

   // Circular priority scan starting at the round-robin pointer.
   always_comb begin
      winner_d = ptr_q;
      found    = 1'b0;
      scanSum  = 0;
      scanIdx  = '0;
      for (int i = 0; i < N; i++) begin
         scanSum = int'(ptr_q) + i;
         if (scanSum >= N) scanSum = scanSum - N;
         scanIdx = SW'(scanSum);
         if (!found && req[scanIdx]) begin
            winner_d = scanIdx;
            found    = 1'b1;
         end
      end
   end

   assign anyReq = |req;
   assign ptr_d  = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;

`ifdef HOLD_LIMIT_EN
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   logic [HW-1:0] holdCnt_q;

   // Counts cycles already spent in GRANT; it sits at zero in every other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdCnt_q <= '0;
      end else if (state_q != GRANT) begin
         holdCnt_q <= '0;
      end else begin
         holdCnt_q <= holdCnt_q + 1'b1;
      end
   end

   assign holdExpired = (holdCnt_q == HW'(MAX_HOLD - 1));
`else
   assign holdExpired = 1'b0;
`endif

   // Every path out of GRANT passes through TURN, so two enables never touch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         sel_q     <= '0;
         ptr_q     <= '0;
         busy_q    <= 1'b0;
         turnCnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (anyReq) begin
                  gnt_q   <= ONE_HOT0 << winner_d;
                  sel_q   <= winner_d;
                  busy_q  <= 1'b1;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (!req[sel_q] || holdExpired) begin
                  gnt_q     <= '0;
                  busy_q    <= 1'b0;
                  ptr_q     <= ptr_d;
                  turnCnt_q <= '0;
                  state_q   <= TURN;
               end
            end
            TURN: begin
               if (turnCnt_q == TW'(TURN_CYC - 1)) begin
                  if (anyReq) begin
                     gnt_q   <= ONE_HOT0 << winner_d;
                     sel_q   <= winner_d;
                     busy_q  <= 1'b1;
                     state_q <= GRANT;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  turnCnt_q <= turnCnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;

endmodule
